// File: rtl/midi_msg_assembler.sv
// Assembles MIDI UART bytes into complete channel-voice messages with running status.
// Real-time bytes are transparent, system bytes cancel running status, and each message is emitted as a one-cycle pulse.
module midi_msg_assembler #(
  parameter bit VEL0_TO_NOTEOFF = 1'b1,
  parameter bit OMNI            = 1'b1,
  parameter int CHANNEL         = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DAT,
  input  logic        RX_RDY,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_WAIT_D1,
    S_WAIT_D2
  } state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } msg_t;

  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  data1_q, data1_d;
  msg_t        msg_q, msg_d;
  logic        rdy_q, rdy_d;

  logic        is_sys;
  logic        is_chan;
  logic        is_data;
  logic        two_data;
  logic        emit;
  logic        chan_pass;
  logic        vel0_note_on;
  msg_t        raw_msg;

  // Byte classes. Real-time bytes (F8-FF) fall in none of them, so they leave all state untouched.
  always_comb begin
    is_sys   = RX_RDY && (RX_DAT[7:3] == 5'b11110);
    is_chan  = RX_RDY && RX_DAT[7] && (RX_DAT[7:4] != 4'hF);
    is_data  = RX_RDY && !RX_DAT[7];
    two_data = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);
  end

  // State register, also holding the registered outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q  <= S_IDLE;
      status_q <= 8'h00;
      data1_q  <= 7'h00;
      msg_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      data1_q  <= data1_d;
      msg_q    <= msg_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_d  = state_q;
    status_d = status_q;
    data1_d  = data1_q;

    if (is_sys) begin
      state_d  = S_SKIP;
      status_d = 8'h00;
      data1_d  = 7'h00;
    end else if (is_chan) begin
      state_d  = S_WAIT_D1;
      status_d = RX_DAT;
      data1_d  = 7'h00;
    end else if (is_data) begin
      unique case (state_q)
        S_WAIT_D1: begin
          data1_d = RX_DAT[6:0];
          if (two_data) begin
            state_d = S_WAIT_D2;
          end
        end
        S_WAIT_D2: begin
          state_d = S_WAIT_D1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output logic: message composition, velocity-0 rewrite and channel filter.
  always_comb begin
    emit         = is_data &&
                   (((state_q == S_WAIT_D1) && !two_data) || (state_q == S_WAIT_D2));
    raw_msg      = '0;
    vel0_note_on = 1'b0;

    if (state_q == S_WAIT_D2) begin
      raw_msg.status = status_q;
      raw_msg.data1  = {1'b0, data1_q};
      raw_msg.data2  = RX_DAT;
      vel0_note_on   = VEL0_TO_NOTEOFF && (status_q[7:4] == 4'h9) && (RX_DAT == 8'h00);
    end else begin
      raw_msg.status = status_q;
      raw_msg.data1  = RX_DAT;
      raw_msg.data2  = 8'h00;
    end

    if (vel0_note_on) begin
      raw_msg.status = {4'h8, status_q[3:0]};
      raw_msg.data2  = 8'h40;
    end

    chan_pass = OMNI || (status_q[3:0] == CHAN);
    // A filtered message still completes in the FSM but neither pulses nor disturbs the held output.
    rdy_d     = emit && chan_pass;
    msg_d     = rdy_d ? raw_msg : msg_q;
  end

  assign MIDI_MSG     = msg_q;
  assign MIDI_MSG_RDY = rdy_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Directed bench for midi_msg_assembler: two instances (default and filtered/no-rewrite) share one byte stream,
// each with its own queue of expected messages tagged with the cycle the pulse must appear in.
module tb_midi_msg_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_dat;
  logic        rx_rdy;
  logic [23:0] msg_a, msg_b;
  logic        rdy_a, rdy_b;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int unsigned cyc;
    logic [23:0] msg;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Default parameters: omni, velocity-0 note-on rewritten to note-off.
  midi_msg_assembler dut_a (
    .CLK          (clk),
    .RST          (rst),
    .RX_DAT       (rx_dat),
    .RX_RDY       (rx_rdy),
    .MIDI_MSG     (msg_a),
    .MIDI_MSG_RDY (rdy_a)
  );

  // Channel 0 only, velocity-0 note-on passed through unchanged.
  midi_msg_assembler #(
    .VEL0_TO_NOTEOFF (1'b0),
    .OMNI            (1'b0),
    .CHANNEL         (0)
  ) dut_b (
    .CLK          (clk),
    .RST          (rst),
    .RX_DAT       (rx_dat),
    .RX_RDY       (rx_rdy),
    .MIDI_MSG     (msg_b),
    .MIDI_MSG_RDY (rdy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_a(input logic [23:0] m);
    exp_t e;
    e.cyc = cyc + 1;
    e.msg = m;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [23:0] m);
    exp_t e;
    e.cyc = cyc + 1;
    e.msg = m;
    q_b.push_back(e);
  endtask

  task automatic push_ab(input logic [23:0] m);
    push_a(m);
    push_b(m);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dat = b;
    rx_rdy = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_rdy = 1'b0;
      rx_dat = 8'h00;
    end
  endtask

  // Scoreboard monitors: pop on each pulse, and flag pulses that are late, early or unexpected.
  always @(negedge clk) begin
    if (rdy_a) begin
      if (q_a.size() == 0) begin
        check("a_spurious_pulse", rdy_a, 1'b0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_pulse_cycle", cyc, e.cyc);
        check("a_msg", msg_a, e.msg);
      end
    end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      check("a_pulse_missing", rdy_a, 1'b1);
      void'(q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rdy_b) begin
      if (q_b.size() == 0) begin
        check("b_spurious_pulse", rdy_b, 1'b0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_pulse_cycle", cyc, e.cyc);
        check("b_msg", msg_b, e.msg);
      end
    end else if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      check("b_pulse_missing", rdy_b, 1'b1);
      void'(q_b.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    rx_rdy = 1'b0;
    rx_dat = 8'h00;
    idle(3);
    check("reset_msg_a", msg_a, 24'h0);
    check("reset_rdy_a", rdy_a, 1'b0);
    check("reset_msg_b", msg_b, 24'h0);
    check("reset_rdy_b", rdy_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Plain note-on.
    send(8'h90); send(8'h3C); send(8'h64); push_ab(24'h903C64);
    idle(2);

    // Running status, including velocity-0 note-on on the last message.
    send(8'h90); send(8'h3C); send(8'h64); push_ab(24'h903C64);
    send(8'h40); send(8'h50); push_ab(24'h904050);
    send(8'h3C); send(8'h00); push_a(24'h803C40); push_b(24'h903C00);
    idle(2);

    // One-data-byte messages on channel 5 (filtered out by dut_b), with running status on Dn.
    send(8'hC5); send(8'h07); push_a(24'hC50700);
    send(8'hD5); send(8'h22); push_a(24'hD52200);
    send(8'h23); push_a(24'hD52300);
    idle(2);

    // Real-time bytes interleaved inside a message.
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64); push_ab(24'h903C64);
    idle(1);

    // Partial note-on abandoned by a new status byte.
    send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h40); push_ab(24'h803C40);
    idle(2);

    // Sysex then orphan data: nothing emitted.
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C); send(8'h64);
    idle(2);

    // Note-off with velocity 0 is not rewritten; aftertouch with pressure 0 is not rewritten.
    send(8'h80); send(8'h3C); send(8'h00); push_ab(24'h803C00);
    send(8'hA0); send(8'h3C); send(8'h00); push_ab(24'hA03C00);
    send(8'hE0); send(8'h00); send(8'h40); push_ab(24'hE00040);
    idle(1);

    // Channel 1: emitted by the omni instance only.
    send(8'h91); send(8'h3C); send(8'h64); push_a(24'h913C64);
    idle(2);
    check("hold_msg_a", msg_a, 24'h913C64);
    check("hold_msg_b", msg_b, 24'hE00040);

    // Reset mid-message, with a byte strobed during reset; the trailing data byte must be ignored.
    send(8'h90); send(8'h3C);
    @(negedge clk);
    rst    = 1'b1;
    rx_rdy = 1'b1;
    rx_dat = 8'h64;
    @(negedge clk);
    rst    = 1'b0;
    rx_rdy = 1'b0;
    send(8'h64);
    idle(3);
    check("post_reset_msg_a", msg_a, 24'h0);
    check("post_reset_msg_b", msg_b, 24'h0);

    send(8'h90); send(8'h3C); send(8'h64); push_ab(24'h903C64);
    idle(4);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
